sram_port_arbiter: RTL and testbench

- Shares the single asynchronous 16-bit SRAM port between the audio recorder (write requester) and the DSP/player (read requester).
- Replaces the state-based address/data muxing in the top level with explicit request/acknowledge handshakes and fixed-length SRAM access timing.
- Uses round-robin arbitration and turnaround-safe DQ tristate control.
- Sits between the recorder and DSP blocks and the SRAM pins; LB_N/UB_N are tied low outside this block.

---
 rtl/sram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM port between a write requester
// (recorder) and a read requester (DSP), with fixed-length access timing and safe DQ turnaround.
module sram_port_arbiter #(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 16,
   parameter int WR_CYCLES = 2,
   parameter int RD_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ack,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_dq_out,
   output logic              o_sram_dq_oe,
   input  logic [DATA_W-1:0] i_sram_dq_in,
   output logic              o_sram_we_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_ce_n,
   output logic              o_busy
);

   localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_W_HOLD,
      S_READ,
      S_R_DONE
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cntNext;
   logic             r_lastGrantWr;
   logic             w_grantWr;
   logic             w_grantRd;
   logic             w_capture;

   // On a tie the requester that was not served last wins.
   always_comb begin
      w_nextState = r_state;
      w_cntNext   = r_cnt;
      w_grantWr   = 1'b0;
      w_grantRd   = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_wr_req && (!i_rd_req || !r_lastGrantWr)) begin
               w_grantWr   = 1'b1;
               w_nextState = S_WRITE;
               w_cntNext   = '0;
            end else if (i_rd_req) begin
               w_grantRd   = 1'b1;
               w_nextState = S_READ;
               w_cntNext   = '0;
            end
         end
         S_WRITE: begin
            if (r_cnt == WR_LAST) begin
               w_nextState = S_W_HOLD;
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end
         S_W_HOLD: w_nextState = S_IDLE;
         S_READ: begin
            if (r_cnt == RD_LAST) begin
               w_capture   = 1'b1;
               w_nextState = S_R_DONE;
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end
         S_R_DONE: w_nextState = S_IDLE;
         default:  w_nextState = S_IDLE;
      endcase
   end

   // Pin controls are decoded from the next state so every output is a flop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_lastGrantWr <= 1'b0;
         o_sram_addr   <= '0;
         o_sram_dq_out <= '0;
         o_rd_data     <= '0;
         o_sram_dq_oe  <= 1'b0;
         o_wr_ack      <= 1'b0;
         o_rd_valid    <= 1'b0;
         o_busy        <= 1'b0;
         o_sram_we_n   <= 1'b1;
         o_sram_oe_n   <= 1'b1;
         o_sram_ce_n   <= 1'b1;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_cntNext;
         if (w_grantWr) begin
            o_sram_addr   <= i_wr_addr;
            o_sram_dq_out <= i_wr_data;
            r_lastGrantWr <= 1'b1;
         end
         if (w_grantRd) begin
            o_sram_addr   <= i_rd_addr;
            r_lastGrantWr <= 1'b0;
         end
         if (w_capture) begin
            o_rd_data <= i_sram_dq_in;
         end
         o_sram_ce_n  <= (w_nextState == S_IDLE);
         o_sram_we_n  <= (w_nextState != S_WRITE);
         o_sram_oe_n  <= (w_nextState != S_READ);
         o_sram_dq_oe <= (w_nextState == S_WRITE) || (w_nextState == S_W_HOLD);
         o_wr_ack     <= (w_nextState == S_W_HOLD);
         o_rd_valid   <= (w_nextState == S_R_DONE);
         o_busy       <= (w_nextState != S_IDLE);
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a small behavioural SRAM.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wrReq = 1'b0;
   logic [19:0] wrAddr = '0;
   logic [15:0] wrData = '0;
   logic        wrAck;
   logic        rdReq = 1'b0;
   logic [19:0] rdAddr = '0;
   logic [15:0] rdData;
   logic        rdValid;
   logic [19:0] sramAddr;
   logic [15:0] sramDqOut;
   logic        sramDqOe;
   logic [15:0] sramDqIn;
   logic        sramWeN;
   logic        sramOeN;
   logic        sramCeN;
   logic        busy;

   // Bus vector order: {we_n, oe_n, ce_n, dq_oe, wr_ack, rd_valid, busy}
   localparam logic [6:0] B_IDLE   = 7'b1110000;
   localparam logic [6:0] B_WRITE  = 7'b0101001;
   localparam logic [6:0] B_W_HOLD = 7'b1101101;
   localparam logic [6:0] B_READ   = 7'b1000001;
   localparam logic [6:0] B_R_DONE = 7'b1100011;

   int assertCount = 0;
   int failCount   = 0;

   sram_port_arbiter #(
      .ADDR_W(20), .DATA_W(16), .WR_CYCLES(2), .RD_CYCLES(2)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_wr_req(wrReq), .i_wr_addr(wrAddr), .i_wr_data(wrData), .o_wr_ack(wrAck),
      .i_rd_req(rdReq), .i_rd_addr(rdAddr), .o_rd_data(rdData), .o_rd_valid(rdValid),
      .o_sram_addr(sramAddr), .o_sram_dq_out(sramDqOut), .o_sram_dq_oe(sramDqOe),
      .i_sram_dq_in(sramDqIn), .o_sram_we_n(sramWeN), .o_sram_oe_n(sramOeN),
      .o_sram_ce_n(sramCeN), .o_busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM, low address byte only.
   logic [15:0] mem [0:255];
   always @(posedge clk) begin
      if (!sramCeN && !sramWeN && sramDqOe) mem[sramAddr[7:0]] <= sramDqOut;
   end
   assign sramDqIn = (!sramCeN && !sramOeN) ? mem[sramAddr[7:0]] : 16'hDEAD;

   // Bus monitor sampled on the falling edge.
   int weLowCnt = 0, dqOeCnt = 0, oeLowCnt = 0, ackCnt = 0, validCnt = 0;
   int turnViol = 0, gapViol = 0;
   bit grants[$];
   bit prevBusy = 1'b0;
   bit prevDone = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (!sramWeN) weLowCnt++;
         if (sramDqOe) dqOeCnt++;
         if (!sramOeN) oeLowCnt++;
         if (wrAck) ackCnt++;
         if (rdValid) validCnt++;
         if (sramDqOe && !sramOeN) turnViol++;
         if (prevDone && busy) gapViol++;
         if (busy && !prevBusy) grants.push_back(!sramWeN);
         prevBusy = busy;
         prevDone = wrAck || rdValid;
      end else begin
         prevBusy = 1'b0;
         prevDone = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkBus(input string tag, input logic [6:0] expected);
      checkOutput(tag, 32'({sramWeN, sramOeN, sramCeN, sramDqOe, wrAck, rdValid, busy}), 32'(expected));
   endtask

   task automatic applyStimulus(input bit wr, input logic [19:0] wa, input logic [15:0] wd,
                                input bit rd, input logic [19:0] ra);
      wrReq  = wr;
      wrAddr = wa;
      wrData = wd;
      rdReq  = rd;
      rdAddr = ra;
   endtask

   task automatic waitPulse(input string tag, input bit wantWr, input int maxCycles);
      bit seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         tick();
         seen = wantWr ? wrAck : rdValid;
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      int snapWe, snapOe, snapOeLow, snapAck, snapValid, snapTurn, snapGap, g0, done;
      $display("[TB] start");
      repeat (3) tick();
      checkBus("reset_bus", B_IDLE);
      checkOutput("reset_addr", 32'(sramAddr), 32'h0);
      checkOutput("reset_dqout", 32'(sramDqOut), 32'h0);
      checkOutput("reset_rddata", 32'(rdData), 32'h0);
      rst = 1'b0;
      tick();

      // Single write
      snapWe = weLowCnt; snapOe = dqOeCnt; snapAck = ackCnt;
      applyStimulus(1, 20'h00010, 16'hBEEF, 0, 20'h0);
      tick();
      checkBus("wr_c1", B_WRITE);
      checkOutput("wr_c1_addr", 32'(sramAddr), 32'h10);
      checkOutput("wr_c1_dq", 32'(sramDqOut), 32'hBEEF);
      tick();
      checkBus("wr_c2", B_WRITE);
      tick();
      checkBus("wr_hold", B_W_HOLD);
      checkOutput("wr_hold_addr", 32'(sramAddr), 32'h10);
      checkOutput("wr_hold_dq", 32'(sramDqOut), 32'hBEEF);
      applyStimulus(0, 20'h0, 16'h0, 0, 20'h0);
      tick();
      checkBus("wr_idle", B_IDLE);
      tick();
      checkOutput("wr_we_low_cycles", 32'(weLowCnt - snapWe), 32'd2);
      checkOutput("wr_dq_oe_cycles", 32'(dqOeCnt - snapOe), 32'd3);
      checkOutput("wr_ack_pulses", 32'(ackCnt - snapAck), 32'd1);

      // Single read of the same location
      snapOeLow = oeLowCnt; snapOe = dqOeCnt; snapValid = validCnt;
      applyStimulus(0, 20'h0, 16'h0, 1, 20'h00010);
      tick();
      checkBus("rd_c1", B_READ);
      tick();
      checkBus("rd_c2", B_READ);
      tick();
      checkBus("rd_done", B_R_DONE);
      checkOutput("rd_data", 32'(rdData), 32'hBEEF);
      applyStimulus(0, 20'h0, 16'h0, 0, 20'h0);
      tick();
      checkBus("rd_idle", B_IDLE);
      tick();
      checkOutput("rd_data_held", 32'(rdData), 32'hBEEF);
      checkOutput("rd_oe_low_cycles", 32'(oeLowCnt - snapOeLow), 32'd2);
      checkOutput("rd_dq_oe_cycles", 32'(dqOeCnt - snapOe), 32'd0);
      checkOutput("rd_valid_pulses", 32'(validCnt - snapValid), 32'd1);

      // Continuous contention, 8 transactions
      g0 = grants.size(); snapTurn = turnViol; snapGap = gapViol; done = 0;
      applyStimulus(1, 20'h00020, 16'h5555, 1, 20'h00010);
      for (int i = 0; i < 80 && done < 8; i++) begin
         tick();
         if (wrAck || rdValid) done++;
      end
      applyStimulus(0, 20'h0, 16'h0, 0, 20'h0);
      checkOutput("rr_completed", 32'(done), 32'd8);
      repeat (4) tick();
      checkOutput("rr_grant_count", 32'(grants.size() - g0), 32'd8);
      for (int i = 0; i < 8 && (g0 + i) < grants.size(); i++) begin
         checkOutput($sformatf("rr_grant%0d", i), 32'(grants[g0 + i]), 32'((i % 2) == 0));
      end
      checkOutput("rr_turnaround", 32'(turnViol - snapTurn), 32'd0);
      checkOutput("rr_idle_gap", 32'(gapViol - snapGap), 32'd0);
      checkOutput("rr_rd_data", 32'(rdData), 32'hBEEF);

      // Requester drops one cycle after the ack cycle
      snapWe = weLowCnt; snapAck = ackCnt;
      applyStimulus(1, 20'h00030, 16'h1111, 0, 20'h0);
      waitPulse("late_ack_seen", 1, 10);
      tick();
      applyStimulus(0, 20'h0, 16'h0, 0, 20'h0);
      repeat (6) tick();
      checkOutput("late_ack_pulses", 32'(ackCnt - snapAck), 32'd1);
      checkOutput("late_we_low_cycles", 32'(weLowCnt - snapWe), 32'd2);

      // Reset during the first WRITE cycle
      applyStimulus(1, 20'h00040, 16'h2222, 0, 20'h0);
      tick();
      checkBus("rst_pre", B_WRITE);
      rst = 1'b1;
      tick();
      checkBus("rst_abort", B_IDLE);
      checkOutput("rst_rddata", 32'(rdData), 32'h0);
      rst = 1'b0;
      applyStimulus(0, 20'h0, 16'h0, 0, 20'h0);
      snapAck = ackCnt;
      repeat (4) tick();
      checkOutput("rst_no_ack", 32'(ackCnt - snapAck), 32'd0);
      applyStimulus(1, 20'h00050, 16'h3333, 1, 20'h00010);
      tick();
      checkBus("rst_tie_wr_first", B_WRITE);
      waitPulse("rst_tie_wr_ack", 1, 10);
      applyStimulus(0, 20'h0, 16'h0, 1, 20'h00010);
      waitPulse("rst_tie_rd_valid", 0, 10);
      applyStimulus(0, 20'h0, 16'h0, 0, 20'h0);
      checkOutput("rst_tie_rd_data", 32'(rdData), 32'hBEEF);
      tick();

      // Write then read at 0x3FFFF, data changed mid-write
      applyStimulus(1, 20'h3FFFF, 16'h1234, 0, 20'h0);
      tick();
      applyStimulus(1, 20'h3FFFF, 16'hFFFF, 0, 20'h0);
      tick();
      tick();
      checkBus("raw_hold", B_W_HOLD);
      checkOutput("raw_hold_dq", 32'(sramDqOut), 32'h1234);
      checkOutput("raw_hold_addr", 32'(sramAddr), 32'h3FFFF);
      applyStimulus(0, 20'h0, 16'h0, 0, 20'h0);
      tick();
      applyStimulus(0, 20'h0, 16'h0, 1, 20'h3FFFF);
      waitPulse("raw_rd_valid", 0, 10);
      checkOutput("raw_rd_data", 32'(rdData), 32'h1234);
      applyStimulus(0, 20'h0, 16'h0, 0, 20'h0);
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
